// File: rtl/key_write_arbiter.sv
// Shares one RAM write port between CPU writeback and a keyboard logger.
// The CPU always wins; buffered key codes are written as a code/count pair.
module key_write_arbiter #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR   = 8'hF0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCpuWe,
  input  logic [ADDR_WIDTH-1:0] iCpuAddr,
  input  logic [DATA_WIDTH-1:0] iCpuData,
  input  logic                  iKeyValid,
  input  logic [7:0]            iKeyCode,
  input  logic                  iOverflowClr,
  output logic                  oWe,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oKeyBusy,
  output logic [2:0]            oFifoLevel,
  output logic                  oOverflow
);

  localparam int                    PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [2:0]            LVL_FULL = 3'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = KEY_ADDR + ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_CODE, S_COUNT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       level_q, level_d;
  logic [15:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic pop, push_ok, drop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A push at full is only accepted when the FSM frees a slot in the same cycle.
  always_comb begin
    pop     = (state_q == S_CODE) && !iCpuWe;
    push_ok = iKeyValid && ((level_q != LVL_FULL) || pop);
    drop    = iKeyValid && (level_q == LVL_FULL) && !pop;
  end

  always_comb begin
    wr_ptr_d = push_ok ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
    count_d = ((state_q == S_COUNT) && !iCpuWe) ? count_q + 16'd1 : count_q;
    ovf_d   = drop ? 1'b1 : (iOverflowClr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= iKeyCode;
  end

  // A CPU write stalls the FSM in place so the deferred key write is retried.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (level_q != 3'd0) state_d = S_CODE;
      S_CODE:  if (!iCpuWe) state_d = S_COUNT;
      S_COUNT: if (!iCpuWe) state_d = (level_q != 3'd0) ? S_CODE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oWe   = 1'b0;
    oAddr = '0;
    oData = '0;
    if (!Reset) begin
      if (iCpuWe) begin
        oWe   = 1'b1;
        oAddr = iCpuAddr;
        oData = iCpuData;
      end else if (state_q == S_CODE) begin
        oWe   = 1'b1;
        oAddr = KEY_ADDR;
        oData = DATA_WIDTH'(mem_q[rd_ptr_q]);
      end else if (state_q == S_COUNT) begin
        oWe   = 1'b1;
        oAddr = CNT_ADDR;
        oData = DATA_WIDTH'(count_q + 16'd1);
      end
    end
  end

  assign oKeyBusy   = (state_q != S_IDLE);
  assign oFifoLevel = level_q;
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_key_write_arbiter.sv
// Scoreboard bench for key_write_arbiter: every RAM write seen on oWe is
// matched in order against a queue of expected {addr,data} words.
module tb_key_write_arbiter;

  logic        Clock, Reset;
  logic        iCpuWe;
  logic [7:0]  iCpuAddr;
  logic [15:0] iCpuData;
  logic        iKeyValid;
  logic [7:0]  iKeyCode;
  logic        iOverflowClr;
  logic        oWe;
  logic [7:0]  oAddr;
  logic [15:0] oData;
  logic        oKeyBusy;
  logic [2:0]  oFifoLevel;
  logic        oOverflow;

  key_write_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .iKeyValid(iKeyValid), .iKeyCode(iKeyCode), .iOverflowClr(iOverflowClr),
    .oWe(oWe), .oAddr(oAddr), .oData(oData),
    .oKeyBusy(oKeyBusy), .oFifoLevel(oFifoLevel), .oOverflow(oOverflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          nvec  = 0;
  int          nfail = 0;
  logic [23:0] exp_q[$];
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every write presented on the RAM port must be the next expected one.
  always @(negedge Clock) begin
    logic [23:0] e;
    if (oWe === 1'b1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", oAddr, oData);
      end else begin
        e = exp_q.pop_front();
        if ({oAddr, oData} !== e) begin
          nfail++;
          $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                   oAddr, oData, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic exp_key(input logic [7:0] code);
    exp_q.push_back({8'hF0, 8'h00, code});
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back({8'hF1, exp_cnt});
  endtask

  task automatic cyc(input logic we, input logic [7:0] a, input logic [15:0] d,
                     input logic kv, input logic [7:0] kc, input logic clr);
    iCpuWe = we; iCpuAddr = a; iCpuData = d;
    iKeyValid = kv; iKeyCode = kc; iOverflowClr = clr;
    if (we) exp_q.push_back({a, d});
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_cnt = 16'd0;
    Reset = 1'b1; iCpuWe = 1'b1; iCpuAddr = 8'h55; iCpuData = 16'h1234;
    iKeyValid = 1'b0; iKeyCode = 8'h00; iOverflowClr = 1'b0;
    #3;
    chk("reset_we",    32'(oWe),        32'd0);
    chk("reset_level", 32'(oFifoLevel), 32'd0);
    chk("reset_ovf",   32'(oOverflow),  32'd0);
    chk("reset_busy",  32'(oKeyBusy),   32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0; iCpuWe = 1'b0;

    // Single key with idle CPU
    exp_key(8'h1C);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 8'h1C, 1'b0);
    idle(1);
    chk("single_busy_mid", 32'(oKeyBusy), 32'd1);
    idle(3);
    chk("single_busy_end", 32'(oKeyBusy), 32'd0);

    // Key arriving during a 5-cycle CPU burst
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'(8'h10 + i), 16'(16'hA000 + i), i == 0, 8'h32, 1'b0);
    exp_key(8'h32);
    iCpuWe = 1'b0; iKeyValid = 1'b0;
    #2;
    chk("contend_code_addr", 32'({oWe, oAddr}), 32'h1F0);
    chk("contend_code_data", 32'(oData), 32'h0032);
    @(posedge Clock);
    #3;
    chk("contend_cnt_addr", 32'({oWe, oAddr}), 32'h1F1);
    chk("contend_cnt_data", 32'(oData), 32'h0002);
    idle(3);
    chk("contend_busy_end", 32'(oKeyBusy), 32'd0);

    // Overflow: fifth key dropped, set beats a same-cycle clear
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'(8'h20 + i), 16'(16'hB000 + i), 1'b1, 8'(i + 1), 1'b0);
    chk("ovf_level", 32'(oFifoLevel), 32'd4);
    chk("ovf_flag",  32'(oOverflow),  32'd1);
    cyc(1'b1, 8'h25, 16'hB005, 1'b1, 8'h06, 1'b1);
    chk("ovf_set_wins", 32'(oOverflow),  32'd1);
    chk("ovf_level2",   32'(oFifoLevel), 32'd4);
    for (int i = 1; i <= 4; i++) exp_key(8'(i));
    cyc(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", 32'(oOverflow), 32'd0);
    idle(10);
    chk("ovf_drained", 32'(oFifoLevel), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'(8'h30 + i), 16'(16'hC000 + i), 1'b1, 8'(8'hA1 + i), 1'b0);
    chk("full_level", 32'(oFifoLevel), 32'd4);
    for (int i = 0; i < 5; i++) exp_key(8'(8'hA1 + i));
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 8'hA5, 1'b0);
    chk("pushpop_level", 32'(oFifoLevel), 32'd4);
    chk("pushpop_ovf",   32'(oOverflow),  32'd0);
    idle(14);
    chk("pushpop_drained", 32'(oFifoLevel), 32'd0);

    // Reset in COUNT abandons the count write
    exp_q.push_back({8'hF0, 16'h005A});
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 8'h5A, 1'b0);
    idle(2);
    chk("midrst_busy_before", 32'(oKeyBusy), 32'd1);
    Reset = 1'b1; iCpuWe = 1'b1; iCpuAddr = 8'h77; iCpuData = 16'h7777;
    #1;
    chk("midrst_we",    32'(oWe),        32'd0);
    chk("midrst_level", 32'(oFifoLevel), 32'd0);
    chk("midrst_busy",  32'(oKeyBusy),   32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0; iCpuWe = 1'b0;
    exp_cnt = 16'd0;
    idle(3);
    exp_key(8'h66);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 8'h66, 1'b0);
    idle(5);

    // Count wrap from 0xFFFF
    force dut.count_q = 16'hFFFF;
    exp_q.push_back({8'hF0, 16'h0077});
    exp_q.push_back({8'hF1, 16'h0000});
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 8'h77, 1'b0);
    idle(5);
    release dut.count_q;

    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/key_write_arbiter.md
KEY_WRITE_ARBITER -- requirements
Module: key_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the RAM write-data word.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the width of the RAM write address.
REQ-003 Parameter KEY_ADDR, default 8'hF0, SHALL be the RAM address that receives the key code; KEY_ADDR+1 SHALL receive the key count.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL be the number of key codes buffered.
REQ-005 Clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-007 iCpuWe  input  1  CPU writeback request.
REQ-008 iCpuAddr  input  ADDR_WIDTH  CPU write address.
REQ-009 iCpuData  input  DATA_WIDTH  CPU write data.
REQ-010 iKeyValid  input  1  single-cycle strobe, synchronous to Clock, marking a new key code.
REQ-011 iKeyCode  input  8  key code, valid only while iKeyValid=1.
REQ-012 iOverflowClr  input  1  clears the overflow flag.
REQ-013 oWe  output  1  RAM write enable.
REQ-014 oAddr  output  ADDR_WIDTH  RAM write address.
REQ-015 oData  output  DATA_WIDTH  RAM write data.
REQ-016 oKeyBusy  output  1  high when the FSM is not IDLE.
REQ-017 oFifoLevel  output  3  number of buffered key codes (0..FIFO_DEPTH).
REQ-018 oOverflow  output  1  sticky flag: a key code was dropped.

Function
REQ-019 The CPU SHALL have absolute priority: when iCpuWe=1, oWe=1, oAddr=iCpuAddr and oData=iCpuData in the same cycle (combinational, zero latency).
REQ-020 The FSM SHALL have states IDLE, CODE and COUNT.
REQ-021 IDLE: when oFifoLevel>0, the next state SHALL be CODE; otherwise the FSM stays in IDLE and drives no key write.
REQ-022 CODE with iCpuWe=0: oWe=1, oAddr=KEY_ADDR, oData={zero pad, FIFO head}; at the clock edge the head SHALL be popped and the next state SHALL be COUNT.
REQ-023 COUNT with iCpuWe=0: oWe=1, oAddr=KEY_ADDR+1, oData=key count+1; at the clock edge the count register SHALL increment and the next state SHALL be CODE if the FIFO is non-empty after the pop, else IDLE.
REQ-024 In CODE or COUNT with iCpuWe=1, the key write SHALL be deferred: no pop, no count increment, state held.
REQ-025 When oWe is driven by neither the CPU nor the FSM, oWe=0 and oAddr and oData SHALL be 0.
REQ-026 The key count SHALL be a 16-bit register that wraps from 16'hFFFF to 16'h0000.
REQ-027 iKeyValid=1 SHALL push iKeyCode into the FIFO, independent of the FSM and CPU state.
REQ-028 Push and pop in the same cycle SHALL both take effect, leaving oFifoLevel unchanged.
REQ-029 A push when level=FIFO_DEPTH with no same-cycle pop SHALL drop the code, leave the FIFO unchanged and set oOverflow; a push at full with a same-cycle pop SHALL be accepted.
REQ-030 oOverflow SHALL stay set until iOverflowClr=1; if a new overflow and iOverflowClr=1 occur in the same cycle, the set SHALL win.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 oKeyBusy SHALL be 1 exactly when the state is CODE or COUNT.

Reset
REQ-033 Reset=1 SHALL immediately force: state IDLE, FIFO empty (oFifoLevel=0), key count 0, oOverflow=0, oKeyBusy=0.
REQ-034 While Reset=1, oWe SHALL be 0 regardless of iCpuWe.
REQ-035 Reset asserted between CODE and COUNT SHALL abandon the sequence, and no COUNT write SHALL follow.

Verification
REQ-036 Single key: iKeyValid with code 8'h1C, CPU idle -> RAM writes [F0]=0x001C on cycle +2 and [F1]=0x0001 on cycle +3, then oKeyBusy=0.
REQ-037 CPU contention: key 8'h32 pushed while iCpuWe=1 is held for 5 cycles -> all CPU writes pass unchanged; the key writes occur on the first two cycles after iCpuWe falls.
REQ-038 Overflow: 5 keys (0x01..0x05) on consecutive cycles while iCpuWe=1 -> 0x05 dropped, oOverflow=1, oFifoLevel=4; after release, writes follow in order 01..04 with counts 1..4.
REQ-039 Count wrap: preload the count to 0xFFFF via 65535 keys, or force it, then send one key -> [F1]=0x0000.
REQ-040 Reset mid-sequence: assert Reset in COUNT -> no F1 write, oFifoLevel=0 and count=0 immediately.
REQ-041 Simultaneous push/pop at full -> level remains 4 and oOverflow remains 0.
